// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_pkg
//  Purpose  : Shared pattern geometry and loader state encoding, used by the
//             pattern loader and the decoder top level.
//  Revision : 1.0  initial release
// ============================================================================
package pattern_pkg;

    localparam int PAT_W  = 1024;
    localparam int WORD_W = 32;
    localparam int WORDS  = PAT_W / WORD_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width able to index n entries, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_word.sv
`default_nettype none
// ============================================================================
//  Module   : piso_word
//  Purpose  : WORD_W-bit parallel-load shift register, emitting MSB first.
//             Load has priority over shift.
//  Revision : 1.0  initial release
// ============================================================================
module piso_word #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              msb_o
);

    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shreg_d;

    // Next shift-register contents: new word, one-bit left shift, or hold
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = shreg_q << 1;
        end
    end

    // Shift-register storage, cleared by clr
    always_ff @(posedge clk) begin
        if (clr) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[WORD_W-1];

endmodule
`default_nettype wire

// File: rtl/pattern_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_loader
//  Purpose  : Accepts a pattern as PAT_W/WORD_W words and shifts it serially,
//             MSB first, into the decoder program register. Back-to-back
//             words stream with no idle cycle between them.
//  Revision : 1.0  initial release
// ============================================================================
module pattern_loader #(
    parameter int PAT_W  = pattern_pkg::PAT_W,
    parameter int WORD_W = pattern_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              prgm,
    output logic              prgm_en,
    output logic              busy,
    output logic              done
);

    import pattern_pkg::*;

    localparam int c_words  = PAT_W / WORD_W;
    localparam int c_bit_w  = cnt_w(WORD_W);
    localparam int c_word_w = cnt_w(c_words);

    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(WORD_W - 1);
    localparam logic [c_word_w-1:0] c_word_last = c_word_w'(c_words - 1);

    if (PAT_W % WORD_W != 0) begin : g_bad_ratio
        $error("pattern_loader: PAT_W must be a multiple of WORD_W");
    end

    state_e               state_q;
    state_e               state_d;
    logic [c_bit_w-1:0]   bit_cnt_q;
    logic [c_bit_w-1:0]   bit_cnt_d;
    logic [c_word_w-1:0]  word_cnt_q;
    logic [c_word_w-1:0]  word_cnt_d;
    logic                 done_q;
    logic                 done_d;

    logic                 w_last;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_msb;

    // Final bit of the current word is on prgm this cycle
    assign w_last   = (state_q == SHIFT) && (bit_cnt_q == c_bit_last);
    assign wr_ready = (state_q == IDLE) || w_last;
    // A word arriving during clr is dropped
    assign w_accept = wr_valid && wr_ready && !clr;

    // Next-state, counter and shift-register control decode
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        done_d     = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    w_load    = 1'b1;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    bit_cnt_d  = '0;
                    done_d     = (word_cnt_q == c_word_last);
                    word_cnt_d = (word_cnt_q == c_word_last) ? '0
                                                             : word_cnt_q + c_word_w'(1);
                    // Reloading on the final bit keeps a streaming source gap-free
                    if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + c_bit_w'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and done pulse registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
        end
    end

    piso_word #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk     (clk),
        .clr     (clr),
        .load_i  (w_load),
        .shift_i (w_shift),
        .data_i  (wr_data),
        .msb_o   (w_msb)
    );

    // Serial outputs come only from state decode and the shift-register flop
    assign prgm_en = (state_q == SHIFT);
    assign prgm    = prgm_en && w_msb;
    assign busy    = (state_q == SHIFT) || (word_cnt_q != '0);
    assign done    = done_q;

endmodule
`default_nettype wire
